// File: rtl/hilo_if.sv
// HI/LO unit bus: multiplier result, MTHI/MTLO writes, MFHI/MFLO reads and status.
// Handshake: mf_data is consumed only in a cycle with mf_valid && !mf_stall; the requester holds mf_valid/mf_sel while stalled.
interface hilo_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              mul_issue;
  logic              mul_done;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;
  logic              mt_valid;
  logic              mt_sel;
  logic [DATA_W-1:0] mt_data;
  logic              mf_valid;
  logic              mf_sel;
  logic [DATA_W-1:0] mf_data;
  logic              mf_stall;
  logic              busy;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              to_err;

  modport master (
    output flush, mul_issue, mul_done, mul_hi, mul_lo,
    output mt_valid, mt_sel, mt_data, mf_valid, mf_sel,
    input  mf_data, mf_stall, busy, hi_q, lo_q, to_err
  );

  modport slave (
    input  flush, mul_issue, mul_done, mul_hi, mul_lo,
    input  mt_valid, mt_sel, mt_data, mf_valid, mf_sel,
    output mf_data, mf_stall, busy, hi_q, lo_q, to_err
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO architectural registers behind the pipelined multiplier: result capture,
// MT/MF service with stall/bypass, and a watchdog on the multiplier's done strobe.
module hilo_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 6,
  parameter int TO_SLACK = 2
) (
  input  logic       clk,
  input  logic       reset,
  hilo_if.slave      hl,
  output logic [1:0] state_dbg
);

  localparam int TO_CYC = MUL_LAT + TO_SLACK;
  localparam int CNT_W  = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                kill;
  logic                to_err_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      kill     <= 1'b0;
      to_err_r <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      if (hl.mt_valid) begin
        if (hl.mt_sel) hi_r <= hl.mt_data;
        else           lo_r <= hl.mt_data;
      end

      case (state)
        S_IDLE: begin
          if (hl.mul_issue) begin
            state <= S_BUSY;
            cnt   <= CNT_W'(1);
            kill  <= 1'b0;
          end
        end

        S_BUSY: begin
          // Flush outranks a same-cycle done: the killed multiply must not commit.
          if (hl.flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (hl.mul_done) begin
            state <= S_IDLE;
            cnt   <= '0;
            // A younger MT (earlier or this cycle) discards the whole result.
            if (!kill && !hl.mt_valid) begin
              hi_r <= hl.mul_hi;
              lo_r <= hl.mul_lo;
            end
          end else if (cnt == CNT_W'(TO_CYC)) begin
            state    <= S_ERR;
            to_err_r <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (hl.mt_valid) kill <= 1'b1;
        end

        S_ERR: begin
          to_err_r <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic              bypass;
  logic              fwd_mt;
  logic [DATA_W-1:0] mf_mux;

  always_comb begin
    bypass = (state == S_BUSY) && hl.mul_done && !kill;
    fwd_mt = hl.mt_valid && (hl.mt_sel == hl.mf_sel);
    mf_mux = hl.mf_sel ? hi_r : lo_r;
    if (bypass)      mf_mux = hl.mf_sel ? hl.mul_hi : hl.mul_lo;
    else if (fwd_mt) mf_mux = hl.mt_data;
  end

  always_comb begin
    hl.mf_stall = hl.mf_valid && (state == S_BUSY) && !hl.mul_done && !kill;
    hl.mf_data  = hl.mf_valid ? mf_mux : '0;
  end

  assign hl.busy    = (state == S_BUSY);
  assign hl.hi_q    = hi_r;
  assign hl.lo_q    = lo_r;
  assign hl.to_err  = to_err_r;
  assign state_dbg  = state;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: stimulus pushes expected MF read data into a queue,
// a negedge monitor pops it whenever a read is presented unstalled.
module tb_hilo_ctrl;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  hilo_if #(.DATA_W(W)) bus ();

  hilo_ctrl #(.DATA_W(W), .MUL_LAT(6), .TO_SLACK(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .hl        (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.mf_valid && !bus.mf_stall) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mf_data: got %h expected no read", bus.mf_data);
      end else begin
        check("mf_data", bus.mf_data, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic idle_in();
    bus.flush     = 1'b0;
    bus.mul_issue = 1'b0;
    bus.mul_done  = 1'b0;
    bus.mul_hi    = '0;
    bus.mul_lo    = '0;
    bus.mt_valid  = 1'b0;
    bus.mt_sel    = 1'b0;
    bus.mt_data   = '0;
    bus.mf_valid  = 1'b0;
    bus.mf_sel    = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic mul_result(input logic [W-1:0] hi, input logic [W-1:0] lo);
    bus.mul_done = 1'b1;
    bus.mul_hi   = hi;
    bus.mul_lo   = lo;
  endtask

  task automatic mt(input logic sel, input logic [W-1:0] data);
    bus.mt_valid = 1'b1;
    bus.mt_sel   = sel;
    bus.mt_data  = data;
  endtask

  task automatic mf(input logic sel);
    bus.mf_valid = 1'b1;
    bus.mf_sel   = sel;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // T1 reset values
    neg();
    check("rst_hi_q",   bus.hi_q, 32'h0);
    check("rst_lo_q",   bus.lo_q, 32'h0);
    check("rst_busy",   W'(bus.busy), 32'h0);
    check("rst_to_err", W'(bus.to_err), 32'h0);
    check("rst_mf_data", bus.mf_data, 32'h0);
    check("rst_stall",  W'(bus.mf_stall), 32'h0);

    // T2 stall until done, bypass on landing cycle
    cyc(); bus.mul_issue = 1'b1;                          // t0
    cyc(); neg();                                         // t0+1
    check("t2_busy", W'(bus.busy), 32'h1);
    check("t2_mf_idle", bus.mf_data, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      cyc(); mf(1'b0);
      if (k == 2) exp_q.push_back(32'hFFFF_FFFE);
      neg();
      check("t2_stall", W'(bus.mf_stall), 32'h1);
    end
    cyc(); mf(1'b0); mul_result(32'h1, 32'hFFFF_FFFE);    // t0+6
    neg();
    check("t2_stall_land", W'(bus.mf_stall), 32'h0);
    cyc(); neg();                                         // t0+7
    check("t2_lo_q", bus.lo_q, 32'hFFFF_FFFE);
    check("t2_hi_q", bus.hi_q, 32'h1);
    check("t2_busy_end", W'(bus.busy), 32'h0);

    // T3 MTHI during multiply kills the result
    cyc(); bus.mul_issue = 1'b1;                          // t0
    cyc();
    cyc();
    cyc(); mt(1'b1, 32'hA5A5_A5A5);                       // t0+3
    cyc(); mf(1'b0); exp_q.push_back(32'hFFFF_FFFE);      // t0+4
    neg();
    check("t3_no_stall_killed", W'(bus.mf_stall), 32'h0);
    cyc();
    cyc(); mul_result(32'h7, 32'h9);                      // t0+6
    cyc(); neg();                                         // t0+7
    check("t3_hi_q", bus.hi_q, 32'hA5A5_A5A5);
    check("t3_lo_q", bus.lo_q, 32'hFFFF_FFFE);
    check("t3_busy", W'(bus.busy), 32'h0);

    // T4 flush kills in-flight multiply
    cyc(); bus.mul_issue = 1'b1;                          // t0
    cyc();
    cyc();
    cyc(); bus.flush = 1'b1;                              // t0+3
    cyc(); neg();                                         // t0+4
    check("t4_busy_flush", W'(bus.busy), 32'h0);
    cyc();
    cyc(); mul_result(32'hDEAD_0001, 32'hBEEF_0002);      // t0+6
    cyc(); neg();                                         // t0+7
    check("t4_hi_q", bus.hi_q, 32'hA5A5_A5A5);
    check("t4_lo_q", bus.lo_q, 32'hFFFF_FFFE);
    check("t4_busy", W'(bus.busy), 32'h0);

    // T6 MT forwarding to a same-cycle MF, matching and non-matching select
    cyc(); mt(1'b0, 32'h0000_1234); mf(1'b0); exp_q.push_back(32'h0000_1234);
    cyc(); neg();
    check("t6_lo_q", bus.lo_q, 32'h0000_1234);
    cyc(); mt(1'b1, 32'h0000_5555); mf(1'b0); exp_q.push_back(32'h0000_1234);
    cyc(); neg();
    check("t6_hi_q", bus.hi_q, 32'h0000_5555);

    // MT on the mul_done cycle discards both halves of the result
    cyc(); bus.mul_issue = 1'b1;                          // t0
    repeat (5) cyc();                                     // t0+1..t0+5
    cyc(); mul_result(32'h77, 32'h88); mt(1'b0, 32'h55);  // t0+6
    cyc(); neg();                                         // t0+7
    check("mtdone_lo_q", bus.lo_q, 32'h0000_0055);
    check("mtdone_hi_q", bus.hi_q, 32'h0000_5555);
    check("mtdone_busy", W'(bus.busy), 32'h0);

    // Stray mul_done in IDLE is ignored
    cyc(); mul_result(32'h1, 32'h2);
    cyc(); neg();
    check("idle_done_hi", bus.hi_q, 32'h0000_5555);
    check("idle_done_lo", bus.lo_q, 32'h0000_0055);

    // T5 multiplier never returns done
    cyc(); bus.mul_issue = 1'b1;                          // t0
    repeat (6) cyc();                                     // t0+1..t0+6
    cyc(); neg();                                         // t0+7
    check("t5_to_err_early", W'(bus.to_err), 32'h0);
    check("t5_busy_early", W'(bus.busy), 32'h1);
    cyc();                                                // t0+8
    cyc(); mf(1'b1); exp_q.push_back(32'h0000_5555);      // t0+9
    neg();
    check("t5_to_err", W'(bus.to_err), 32'h1);
    check("t5_busy_err", W'(bus.busy), 32'h0);
    check("t5_no_stall", W'(bus.mf_stall), 32'h0);
    cyc(); mt(1'b1, 32'h0000_0BAD); bus.flush = 1'b1; mul_result(32'hFFFF, 32'hFFFF);
    cyc(); bus.mul_issue = 1'b1; neg();
    check("t5_err_mt_hi", bus.hi_q, 32'h0000_0BAD);
    check("t5_err_lo", bus.lo_q, 32'h0000_0055);
    check("t5_err_sticky", W'(bus.to_err), 32'h1);
    cyc(); neg();
    check("t5_err_no_issue", W'(bus.busy), 32'h0);
    check("t5_err_sticky2", W'(bus.to_err), 32'h1);

    // Only reset clears the error
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    neg();
    check("t5_reset_to_err", W'(bus.to_err), 32'h0);
    check("t5_reset_hi", bus.hi_q, 32'h0);
    check("t5_reset_lo", bus.lo_q, 32'h0);

    repeat (2) cyc();
    check("exp_q_drained", W'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
